// File: rtl/fpop_pkg.sv
// fpop_pkg: operator latency constants and tag type shared by the fpop arbiter
package fpop_pkg;
  localparam int FPOP_RI = 0;
  localparam int FPOP_RO = 1;
  localparam int FPOP_RP_ADD = 2;
  localparam int FPOP_RP_MUL = 1;
  localparam int FPOP_IDW = 4;
  function automatic int fpop_lat(input int ri, input int rp, input int ro);
    return ri + rp + ro;
  endfunction
  localparam int FPOP_LAT_ADD = fpop_lat(FPOP_RI, FPOP_RP_ADD, FPOP_RO);
  localparam int FPOP_LAT_MUL = fpop_lat(FPOP_RI, FPOP_RP_MUL, FPOP_RO);
  typedef struct packed {
    logic vld;
    logic [FPOP_IDW-1:0] id;
  } fpop_tag_t;
endpackage

// File: rtl/fpop_arb_if.sv
// fpop_arb_if: requester, operator and result signals of the shared fp operator
interface fpop_arb_if #(parameter int DW = 32, parameter int NR = 4);
  localparam int TW = NR > 1 ? $clog2(NR) : 1;
  logic [NR-1:0] req_vld;
  logic [NR-1:0] req_rdy;
  logic [NR*DW-1:0] req_x;
  logic [NR*DW-1:0] req_y;
  logic op_ena;
  logic [DW-1:0] op_x;
  logic [DW-1:0] op_y;
  logic [DW-1:0] op_r;
  logic res_vld;
  logic [TW-1:0] res_id;
  logic [DW-1:0] res_r;
  logic res_rdy;
  logic busy;
  modport master(output req_vld, req_x, req_y, op_r, res_rdy,
                 input req_rdy, op_ena, op_x, op_y, res_vld, res_id, res_r, busy);
  modport slave(input req_vld, req_x, req_y, op_r, res_rdy,
                output req_rdy, op_ena, op_x, op_y, res_vld, res_id, res_r, busy);
endinterface

// File: rtl/fpop_arb_rr_arb.sv
// rr_arb: NR-way round-robin arbiter, first requester at or above ptr wins
module rr_arb #(
  parameter int NR = 4,
  localparam int TW = NR > 1 ? $clog2(NR) : 1
) (
  input  logic [NR-1:0] req,
  input  logic [TW-1:0] ptr,
  input  logic          en,
  output logic [NR-1:0] gnt,
  output logic [TW-1:0] gnt_id
);
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    for (int k = NR - 1; k >= 0; k--) begin
      if (en && req[(int'(ptr) + k) % NR]) begin
        gnt = NR'(1) << ((int'(ptr) + k) % NR);
        gnt_id = TW'((int'(ptr) + k) % NR);
      end
    end
  end
endmodule

// File: rtl/fpop_arb.sv
// fpop_arb: round-robin sharing of one pipelined fp operator with a tag pipeline
module fpop_arb
  import fpop_pkg::*;
#(
  parameter int DW = 32,
  parameter int NR = 4,
  parameter int LAT = 2,
  localparam int TW = NR > 1 ? $clog2(NR) : 1
) (
  input logic clk,
  input logic rst,
  fpop_arb_if.slave bus
);
  logic stall;
  logic any;
  logic [TW-1:0] ptr;
  logic [TW-1:0] gid;
  fpop_tag_t tag [LAT];
  assign stall = bus.res_vld & ~bus.res_rdy;
  assign bus.op_ena = ~stall & ~rst;
  rr_arb #(.NR(NR)) u_arb (
    .req(bus.req_vld),
    .ptr(ptr),
    .en(bus.op_ena),
    .gnt(bus.req_rdy),
    .gnt_id(gid)
  );
  assign any = |bus.req_rdy;
  assign bus.op_x = any ? bus.req_x[int'(gid)*DW +: DW] : '0;
  assign bus.op_y = any ? bus.req_y[int'(gid)*DW +: DW] : '0;
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (any) ptr <= (int'(gid) == NR - 1) ? '0 : gid + 1'b1;
  end
  // tags advance in lockstep with the operator registers so ids stay aligned with op_r
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) tag[i] <= '0;
    end else if (bus.op_ena) begin
      tag[0] <= fpop_tag_t'{vld: any, id: FPOP_IDW'(gid)};
      for (int i = 1; i < LAT; i++) tag[i] <= tag[i-1];
    end
  end
  always_comb begin
    bus.busy = 1'b0;
    for (int i = 0; i < LAT; i++) bus.busy = bus.busy | tag[i].vld;
  end
  assign bus.res_vld = tag[LAT-1].vld;
  assign bus.res_id = tag[LAT-1].id[TW-1:0];
  assign bus.res_r = bus.op_r;
endmodule

// File: tb/tb_fpop_arb.sv
// tb_fpop_arb: directed checks of fpop_arb with LAT=2 and LAT=3 multiplier models
module tb_fpop_arb;
  logic clk;
  logic rst;
  logic rst3;
  int checks;
  int errors;
  logic [31:0] yt [4];
  logic [31:0] p2 [2];
  logic [31:0] p3 [3];
  fpop_arb_if #(.DW(32), .NR(4)) b2();
  fpop_arb_if #(.DW(32), .NR(4)) b3();
  fpop_arb #(.DW(32), .NR(4), .LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  fpop_arb #(.DW(32), .NR(4), .LAT(3)) dut3 (.clk(clk), .rst(rst3), .bus(b3));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0] e;
    logic s;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    return m[47] ? {s, e[7:0] + 8'd1, m[46:24]} : {s, e[7:0], m[45:23]};
  endfunction
  always @(posedge clk) begin
    if (b2.op_ena) begin
      p2[0] <= fmul(b2.op_x, b2.op_y);
      p2[1] <= p2[0];
    end
    if (b3.op_ena) begin
      p3[0] <= fmul(b3.op_x, b3.op_y);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end
  assign b2.op_r = p2[1];
  assign b3.op_r = p3[2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    yt[0] = 32'h40400000;
    yt[1] = 32'h40800000;
    yt[2] = 32'h40000000;
    yt[3] = 32'h40A00000;
    rst = 1'b1;
    rst3 = 1'b1;
    b2.req_vld = '0;
    b2.res_rdy = 1'b1;
    b3.req_vld = '0;
    b3.res_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b2.req_x[i*32 +: 32] = 32'h3F800000;
      b2.req_y[i*32 +: 32] = yt[i];
      b3.req_x[i*32 +: 32] = 32'h3F800000;
      b3.req_y[i*32 +: 32] = yt[i];
    end
    step();
    b2.req_vld = 4'hF;
    #1;
    chk("rst_rdy", 32'(b2.req_rdy), 32'h0);
    chk("rst_ena", 32'(b2.op_ena), 32'h0);
    step();
    #1;
    chk("rst_res_vld", 32'(b2.res_vld), 32'h0);
    chk("rst_busy", 32'(b2.busy), 32'h0);
    step();
    rst = 1'b0;
    rst3 = 1'b0;
    b2.req_vld = '0;
    step();
    b2.req_vld = 4'b0100;
    #1;
    chk("single_rdy", 32'(b2.req_rdy), 32'h4);
    chk("single_ena", 32'(b2.op_ena), 32'h1);
    chk("single_opx", b2.op_x, 32'h3F800000);
    chk("single_opy", b2.op_y, 32'h40000000);
    step();
    b2.req_vld = '0;
    #1;
    chk("single_t1_vld", 32'(b2.res_vld), 32'h0);
    chk("single_bubble_opx", b2.op_x, 32'h0);
    step();
    #1;
    chk("single_t2_vld", 32'(b2.res_vld), 32'h1);
    chk("single_t2_id", 32'(b2.res_id), 32'h2);
    chk("single_t2_r", b2.res_r, 32'h40000000);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      b2.req_vld = 4'hF;
      #1;
      chk("rr_gnt", 32'(b2.req_rdy), 32'(1 << (k % 4)));
      if (k >= 2) begin
        chk("rr_res_id", 32'(b2.res_id), 32'((k - 2) % 4));
        chk("rr_res_r", b2.res_r, yt[(k - 2) % 4]);
      end else begin
        chk("rr_res_vld0", 32'(b2.res_vld), 32'h0);
      end
    end
    for (int j = 0; j < 3; j++) begin
      step();
      b2.res_rdy = 1'b0;
      #1;
      chk("bp_ena", 32'(b2.op_ena), 32'h0);
      chk("bp_rdy", 32'(b2.req_rdy), 32'h0);
      chk("bp_vld", 32'(b2.res_vld), 32'h1);
      chk("bp_id", 32'(b2.res_id), 32'h2);
      chk("bp_r", b2.res_r, yt[2]);
    end
    step();
    b2.res_rdy = 1'b1;
    #1;
    chk("bp_rel_id", 32'(b2.res_id), 32'h2);
    chk("bp_rel_gnt", 32'(b2.req_rdy), 32'h1);
    step();
    #1;
    chk("bp_c12_id", 32'(b2.res_id), 32'h3);
    chk("bp_c12_gnt", 32'(b2.req_rdy), 32'h2);
    step();
    #1;
    chk("bp_c13_id", 32'(b2.res_id), 32'h0);
    chk("bp_c13_r", b2.res_r, yt[0]);
    chk("bp_c13_gnt", 32'(b2.req_rdy), 32'h4);
    step();
    b2.req_vld = '0;
    #1;
    chk("bp_c14_id", 32'(b2.res_id), 32'h1);
    step();
    #1;
    chk("bp_c15_id", 32'(b2.res_id), 32'h2);
    chk("bp_c15_vld", 32'(b2.res_vld), 32'h1);
    step();
    #1;
    chk("bp_drain_vld", 32'(b2.res_vld), 32'h0);
    chk("bp_drain_busy", 32'(b2.busy), 32'h0);
    step();
    b2.res_rdy = 1'b0;
    b2.req_vld = 4'b0001;
    #1;
    chk("sp_s0_gnt", 32'(b2.req_rdy), 32'h1);
    step();
    b2.req_vld = '0;
    #1;
    chk("sp_s1_ena", 32'(b2.op_ena), 32'h1);
    chk("sp_s1_vld", 32'(b2.res_vld), 32'h0);
    chk("sp_s1_busy", 32'(b2.busy), 32'h1);
    for (int j = 0; j < 3; j++) begin
      step();
      #1;
      chk("sp_stall_ena", 32'(b2.op_ena), 32'h0);
      chk("sp_stall_id", 32'(b2.res_id), 32'h0);
    end
    step();
    b2.req_vld = 4'b0010;
    #1;
    chk("sp_s5_rdy", 32'(b2.req_rdy), 32'h0);
    chk("sp_s5_vld", 32'(b2.res_vld), 32'h1);
    step();
    b2.req_vld = '0;
    b2.res_rdy = 1'b1;
    #1;
    chk("sp_s6_ena", 32'(b2.op_ena), 32'h1);
    chk("sp_s6_r", b2.res_r, yt[0]);
    step();
    #1;
    chk("sp_s7_vld", 32'(b2.res_vld), 32'h0);
    chk("sp_s7_busy", 32'(b2.busy), 32'h0);
    step();
    b2.req_vld = 4'b1010;
    #1;
    chk("ptr_g1", 32'(b2.req_rdy), 32'h2);
    step();
    b2.req_vld = 4'b1011;
    #1;
    chk("ptr_g3", 32'(b2.req_rdy), 32'h8);
    step();
    #1;
    chk("ptr_g0", 32'(b2.req_rdy), 32'h1);
    step();
    #1;
    chk("ptr_g1b", 32'(b2.req_rdy), 32'h2);
    step();
    b2.req_vld = '0;
    b3.req_vld = 4'hF;
    #1;
    chk("l3_g0", 32'(b3.req_rdy), 32'h1);
    step();
    #1;
    chk("l3_g1", 32'(b3.req_rdy), 32'h2);
    step();
    #1;
    chk("l3_g2", 32'(b3.req_rdy), 32'h4);
    step();
    rst3 = 1'b1;
    #1;
    chk("l3_rst_rdy", 32'(b3.req_rdy), 32'h0);
    chk("l3_rst_ena", 32'(b3.op_ena), 32'h0);
    step();
    rst3 = 1'b0;
    #1;
    chk("l3_post_vld", 32'(b3.res_vld), 32'h0);
    chk("l3_post_busy", 32'(b3.busy), 32'h0);
    chk("l3_post_g0", 32'(b3.req_rdy), 32'h1);
    step();
    #1;
    chk("l3_post_g1", 32'(b3.req_rdy), 32'h2);
    chk("l3_post2_vld", 32'(b3.res_vld), 32'h0);
    step();
    #1;
    chk("l3_post3_vld", 32'(b3.res_vld), 32'h0);
    step();
    #1;
    chk("l3_res_vld", 32'(b3.res_vld), 32'h1);
    chk("l3_res_id", 32'(b3.res_id), 32'h0);
    chk("l3_res_r", b3.res_r, yt[0]);
    b3.req_vld = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
